// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared command-frame types and field positions
package cmd_pkg;

  localparam int CMD_PAYLOAD_BYTES = 12;
  localparam int CMD_WORD_W        = 96;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } cmd_state_e;

  // Field slices of the committed command word; bit 15 of each dist is direction.
  localparam int Y_DIST_MSB = 95;
  localparam int Y_DIST_LSB = 80;
  localparam int Y_RPM_MSB  = 79;
  localparam int Y_RPM_LSB  = 64;
  localparam int X_DIST_MSB = 63;
  localparam int X_DIST_LSB = 48;
  localparam int X_RPM_MSB  = 47;
  localparam int X_RPM_LSB  = 32;
  localparam int Z_DIST_MSB = 31;
  localparam int Z_DIST_LSB = 16;
  localparam int Z_RPM_MSB  = 15;
  localparam int Z_RPM_LSB  = 0;
  localparam int DIST_DIR_BIT = 15;

endpackage

// File: rtl/cmd_timeout_ctr.sv
// rtl/cmd_timeout_ctr.sv - loadable down-counter; expire_o is high while the count is zero
module cmd_timeout_ctr #(
  parameter int unsigned W = 17
) (
  input  logic         i_Clk,
  input  logic         i_Rst_L,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/spi_cmd_frame_assembler.sv
// rtl/spi_cmd_frame_assembler.sv - collects SPI command frames, verifies the XOR checksum
// and commits the 96-bit command word atomically.
module spi_cmd_frame_assembler
  import cmd_pkg::*;
#(
  parameter bit          CHECKSUM_EN    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 120000,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_RX_DV,
  input  logic [7:0]            i_RX_Byte,
  input  logic                  i_CS_n,
  output logic [CMD_WORD_W-1:0] o_data_out,
  output logic                  o_frame_valid,
  output logic                  o_frame_err,
  output logic                  o_busy,
  output logic [ERR_CNT_W-1:0]  o_err_cnt
);

  localparam logic [3:0] PAY_BYTES = 4'(CMD_PAYLOAD_BYTES);
  localparam logic [3:0] N_BYTES   = 4'(CMD_PAYLOAD_BYTES + 32'(CHECKSUM_EN));
  localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  cmd_state_e            state_q, state_d;
  logic [CMD_WORD_W-1:0] shadow_q, shadow_d;
  logic [CMD_WORD_W-1:0] data_q, data_d;
  logic [3:0]            byte_cnt_q, byte_cnt_d;
  logic [7:0]            xor_q, xor_d;
  logic [7:0]            csum_q, csum_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  cs_prev_q;
  logic                  cs_rise;
  logic                  tmr_clr, tmr_load, tmr_dec, tmr_expire;

  assign cs_rise = i_CS_n & ~cs_prev_q;

  cmd_timeout_ctr #(.W(TW)) u_timeout (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (TMO_LOAD),
    .dec_i      (tmr_dec),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    data_d     = data_q;
    byte_cnt_d = byte_cnt_q;
    xor_d      = xor_q;
    csum_d     = csum_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    tmr_clr    = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_RX_DV) begin
          shadow_d   = {shadow_q[CMD_WORD_W-9:0], i_RX_Byte};
          byte_cnt_d = 4'd1;
          xor_d      = i_RX_Byte;
          tmr_load   = 1'b1;
          state_d    = ST_RECV;
        end
      end
      ST_RECV: begin
        if (i_RX_DV) begin
          byte_cnt_d = byte_cnt_q + 4'd1;
          tmr_load   = 1'b1;
          if (byte_cnt_q < PAY_BYTES) begin
            shadow_d = {shadow_q[CMD_WORD_W-9:0], i_RX_Byte};
            xor_d    = xor_q ^ i_RX_Byte;
          end else begin
            csum_d = i_RX_Byte;
          end
          // A byte that completes the frame wins over a simultaneous CS release.
          if ((byte_cnt_q + 4'd1) == N_BYTES) begin
            state_d = ST_CHECK;
          end else if (cs_rise) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (cs_rise || tmr_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_CHECK: begin
        if (!CHECKSUM_EN || (csum_q == xor_q)) begin
          data_d  = shadow_q;
          valid_d = 1'b1;
          state_d = ST_COMMIT;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
        if (i_RX_DV) err_d = 1'b1;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (i_RX_DV) err_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      byte_cnt_d = 4'd0;
      if (state_q != ST_IDLE) tmr_clr = 1'b1;
    end

    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      data_q     <= '0;
      byte_cnt_q <= 4'd0;
      xor_q      <= 8'd0;
      csum_q     <= 8'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      cs_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      data_q     <= data_d;
      byte_cnt_q <= byte_cnt_d;
      xor_q      <= xor_d;
      csum_q     <= csum_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      cs_prev_q  <= i_CS_n;
    end
  end

  assign o_data_out    = data_q;
  assign o_frame_valid = valid_q;
  assign o_frame_err   = err_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_err_cnt     = err_cnt_q;

endmodule
